// File: rtl/run_ctrl_pkg.sv
// Shared types and parameter legality check for the core run controller.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HOLD    = 3'd1,
      RELEASE = 3'd2,
      RUN     = 3'd3,
      DONE    = 3'd4
   } run_state_e;

   function automatic bit params_legal(input int rst_hold, input int max_cycles, input int n_ch);
      return (rst_hold >= 1) && (max_cycles >= 1) && (n_ch >= 1);
   endfunction

endpackage

// File: rtl/rst_stagger.sv
// Staggered per-channel reset release: channel i leaves reset i*STAGGER edges after channel 0.
module rst_stagger #(
   parameter int N_CH    = 1,
   parameter int STAGGER = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            launch,
   output logic [N_CH-1:0] core_rst_n,
   output logic            last_go
);

   localparam int LAST = (N_CH - 1) * STAGGER;
   localparam int TW   = $clog2(LAST + 2);
   localparam logic [TW-1:0] LAST_T = TW'(LAST);

   logic          active;
   logic [TW-1:0] tick;
   logic [TW-1:0] tick_next;

   // tick counts edges since launch and saturates once the last channel is out
   always_comb begin
      tick_next = tick;
      if (launch)
         tick_next = '0;
      else if (active && (tick != LAST_T))
         tick_next = tick + 1'b1;
   end

   // high on exactly the edge that releases the final channel
   assign last_go = launch ? (LAST == 0)
                           : (active && (tick != LAST_T) && (tick_next == LAST_T));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active     <= 1'b0;
         tick       <= '0;
         core_rst_n <= '0;
      end else if (clear) begin
         active     <= 1'b0;
         tick       <= '0;
         core_rst_n <= '0;
      end else begin
         if (launch)
            active <= 1'b1;
         tick <= tick_next;
         for (int i = 0; i < N_CH; i++) begin
            if ((launch || active) && (int'(tick_next) >= i * STAGGER))
               core_rst_n[i] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/reset_run_controller.sv
// Run controller for core bring-up: holds resets, releases channels, then times the run
// until the core halts or the cycle budget is spent.
module reset_run_controller
   import run_ctrl_pkg::*;
#(
   parameter int RST_HOLD   = 2,
   parameter int N_CH       = 1,
   parameter int STAGGER    = 0,
   parameter int MAX_CYCLES = 1024,
   parameter int CNT_W      = $clog2(MAX_CYCLES) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             halt,
   output logic [N_CH-1:0]  core_rst_n,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int HW = $clog2(RST_HOLD + 1);

   if (!params_legal(RST_HOLD, MAX_CYCLES, N_CH)) begin : g_bad_params
      $error("reset_run_controller: RST_HOLD, MAX_CYCLES and N_CH must all be >= 1");
   end

   run_state_e    state;
   logic [HW-1:0] hold_cnt;
   logic          abort_now;
   logic          hold_last;
   logic          budget_last;
   logic          launch;
   logic          run_end;
   logic          last_go;

   assign abort_now   = abort && (state != IDLE);
   assign hold_last   = (hold_cnt == HW'(RST_HOLD - 1));
   assign budget_last = (cycle_count == CNT_W'(MAX_CYCLES - 1));
   assign launch      = (state == HOLD) && hold_last && !abort;
   assign run_end     = (state == RUN) && (halt || budget_last);

   rst_stagger #(
      .N_CH    (N_CH),
      .STAGGER (STAGGER)
   ) u_stagger (
      .clk        (clk),
      .rst        (rst),
      .clear      (abort_now || run_end),
      .launch     (launch),
      .core_rst_n (core_rst_n),
      .last_go    (last_go)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         cycle_count <= '0;
         running     <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else if (abort_now) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         cycle_count <= '0;
         running     <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= HOLD;
                  hold_cnt    <= '0;
                  cycle_count <= '0;
                  done        <= 1'b0;
                  timeout     <= 1'b0;
               end
            end
            HOLD: begin
               if (hold_last) begin
                  // single channel or zero stagger goes straight into RUN
                  if (last_go) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end else begin
                     state <= RELEASE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (last_go) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               // halt outranks budget exhaustion on the same edge
               if (halt) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (budget_last) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  cycle_count <= cycle_count + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_run_controller.sv
// Directed bench for reset_run_controller: RST_HOLD=2, N_CH=2, MAX_CYCLES=8, STAGGER=1 and 0.
module tb_reset_run_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic       halt;
   logic [1:0] core_rst_n;
   logic       running;
   logic       done;
   logic       timeout;
   logic [3:0] cycle_count;
   logic [1:0] core_rst_n0;
   logic       running0;
   logic       done0;
   logic       timeout0;
   logic [3:0] cycle_count0;

   int total;
   int bad;

   reset_run_controller #(
      .RST_HOLD(2), .N_CH(2), .STAGGER(1), .MAX_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .halt(halt),
      .core_rst_n(core_rst_n), .running(running), .done(done),
      .timeout(timeout), .cycle_count(cycle_count)
   );

   reset_run_controller #(
      .RST_HOLD(2), .N_CH(2), .STAGGER(0), .MAX_CYCLES(8)
   ) dut0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .halt(halt),
      .core_rst_n(core_rst_n0), .running(running0), .done(done0),
      .timeout(timeout0), .cycle_count(cycle_count0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // abort is a no-op in IDLE, so this parks both instances in IDLE
   task automatic go_idle();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // drives start so it is sampled at edge e0; returns just after e0
   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; abort = 1'b0; halt = 1'b0;
      #2;
      total++; if ({core_rst_n, running, done, timeout, cycle_count} !== 9'b0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", {core_rst_n, running, done, timeout, cycle_count}, 9'b0); end
      ticks(2);
      total++; if ({core_rst_n0, running0, done0, timeout0, cycle_count0} !== 9'b0) begin bad++; $display("FAIL reset_outputs_s0 got=%b want=%b", {core_rst_n0, running0, done0, timeout0, cycle_count0}, 9'b0); end
      #2 rst = 1'b1;
      tick();
      total++; if ({core_rst_n, running, done} !== 4'b0) begin bad++; $display("FAIL reset_release_idle got=%b want=%b", {core_rst_n, running, done}, 4'b0); end
      // asynchronous assertion in the middle of a run
      start_run();
      ticks(4);
      total++; if ({core_rst_n, running, cycle_count} !== 7'b11_1_0001) begin bad++; $display("FAIL async_pre got=%b want=%b", {core_rst_n, running, cycle_count}, 7'b11_1_0001); end
      #3 rst = 1'b0;
      #1;
      total++; if ({core_rst_n, running, done, timeout, cycle_count} !== 9'b0) begin bad++; $display("FAIL async_reset got=%b want=%b", {core_rst_n, running, done, timeout, cycle_count}, 9'b0); end
      total++; if ({core_rst_n0, running0, cycle_count0} !== 7'b0) begin bad++; $display("FAIL async_reset_s0 got=%b want=%b", {core_rst_n0, running0, cycle_count0}, 7'b0); end
      #2 rst = 1'b1;
      tick();
   endtask

   task automatic test_normal_halt();
      go_idle();
      start_run();
      total++; if ({core_rst_n, running} !== 3'b00_0) begin bad++; $display("FAIL halt_e0 got=%b want=%b", {core_rst_n, running}, 3'b000); end
      ticks(2);
      total++; if ({core_rst_n, running} !== 3'b01_0) begin bad++; $display("FAIL halt_e2 got=%b want=%b", {core_rst_n, running}, 3'b010); end
      tick();
      total++; if ({core_rst_n, running, cycle_count} !== 7'b11_1_0000) begin bad++; $display("FAIL halt_e3 got=%b want=%b", {core_rst_n, running, cycle_count}, 7'b11_1_0000); end
      ticks(4);
      total++; if (cycle_count !== 4'd4) begin bad++; $display("FAIL halt_count_e7 got=%0d want=%0d", cycle_count, 4); end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      total++; if ({core_rst_n, running, done, timeout, cycle_count} !== 9'b00_0_1_0_0100) begin bad++; $display("FAIL halt_done got=%b want=%b", {core_rst_n, running, done, timeout, cycle_count}, 9'b000100100); end
      halt = 1'b1;
      ticks(2);
      halt = 1'b0;
      total++; if ({done, timeout, cycle_count} !== 6'b1_0_0100) begin bad++; $display("FAIL halt_hold got=%b want=%b", {done, timeout, cycle_count}, 6'b100100); end
   endtask

   task automatic test_timeout();
      go_idle();
      start_run();
      ticks(10);
      total++; if ({done, running, cycle_count} !== 6'b0_1_0111) begin bad++; $display("FAIL timeout_e10 got=%b want=%b", {done, running, cycle_count}, 6'b010111); end
      tick();
      total++; if ({core_rst_n, running, done, timeout, cycle_count} !== 9'b00_0_1_1_0111) begin bad++; $display("FAIL timeout_e11 got=%b want=%b", {core_rst_n, running, done, timeout, cycle_count}, 9'b000110111); end
      ticks(3);
      total++; if ({done, timeout, cycle_count} !== 6'b1_1_0111) begin bad++; $display("FAIL timeout_hold got=%b want=%b", {done, timeout, cycle_count}, 6'b110111); end
   endtask

   task automatic test_simultaneous();
      go_idle();
      start_run();
      ticks(10);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      total++; if ({done, timeout, cycle_count} !== 6'b1_0_0111) begin bad++; $display("FAIL simul_halt_wins got=%b want=%b", {done, timeout, cycle_count}, 6'b100111); end
   endtask

   task automatic test_abort();
      go_idle();
      start_run();
      ticks(2);
      total++; if ({core_rst_n, running} !== 3'b01_0) begin bad++; $display("FAIL abort_in_release got=%b want=%b", {core_rst_n, running}, 3'b010); end
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      total++; if ({core_rst_n, running, done, timeout, cycle_count} !== 9'b0) begin bad++; $display("FAIL abort_idle got=%b want=%b", {core_rst_n, running, done, timeout, cycle_count}, 9'b0); end
      ticks(2);
      total++; if ({core_rst_n, running} !== 3'b0) begin bad++; $display("FAIL abort_stays_idle got=%b want=%b", {core_rst_n, running}, 3'b0); end
      start_run();
      tick();
      total++; if (core_rst_n !== 2'b00) begin bad++; $display("FAIL abort_replay_e1 got=%b want=%b", core_rst_n, 2'b00); end
      tick();
      total++; if ({core_rst_n, running} !== 3'b01_0) begin bad++; $display("FAIL abort_replay_e2 got=%b want=%b", {core_rst_n, running}, 3'b010); end
      tick();
      total++; if ({core_rst_n, running, cycle_count} !== 7'b11_1_0000) begin bad++; $display("FAIL abort_replay_e3 got=%b want=%b", {core_rst_n, running, cycle_count}, 7'b1110000); end
      // abort during RUN and DONE also clears everything
      abort = 1'b1;
      halt = 1'b1;
      tick();
      abort = 1'b0;
      halt = 1'b0;
      total++; if ({core_rst_n, running, done, cycle_count} !== 8'b0) begin bad++; $display("FAIL abort_in_run got=%b want=%b", {core_rst_n, running, done, cycle_count}, 8'b0); end
   endtask

   task automatic test_restart();
      go_idle();
      start_run();
      ticks(4);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      total++; if ({done, cycle_count} !== 5'b1_0001) begin bad++; $display("FAIL restart_first_done got=%b want=%b", {done, cycle_count}, 5'b10001); end
      start_run();
      total++; if ({core_rst_n, running, done, timeout, cycle_count} !== 9'b0) begin bad++; $display("FAIL restart_clear got=%b want=%b", {core_rst_n, running, done, timeout, cycle_count}, 9'b0); end
      ticks(2);
      total++; if (core_rst_n !== 2'b01) begin bad++; $display("FAIL restart_e2 got=%b want=%b", core_rst_n, 2'b01); end
      tick();
      total++; if ({core_rst_n, running} !== 3'b11_1) begin bad++; $display("FAIL restart_e3 got=%b want=%b", {core_rst_n, running}, 3'b111); end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      total++; if ({core_rst_n, running, done, cycle_count} !== 8'b11_1_0_0010) begin bad++; $display("FAIL restart_start_in_run got=%b want=%b", {core_rst_n, running, done, cycle_count}, 8'b11100010); end
   endtask

   task automatic test_stagger0();
      go_idle();
      start_run();
      tick();
      total++; if ({core_rst_n0, running0} !== 3'b00_0) begin bad++; $display("FAIL s0_e1 got=%b want=%b", {core_rst_n0, running0}, 3'b000); end
      tick();
      total++; if ({core_rst_n0, running0, cycle_count0} !== 7'b11_1_0000) begin bad++; $display("FAIL s0_e2 got=%b want=%b", {core_rst_n0, running0, cycle_count0}, 7'b1110000); end
      ticks(8);
      total++; if ({done0, timeout0, cycle_count0} !== 6'b1_1_0111) begin bad++; $display("FAIL s0_timeout_e10 got=%b want=%b", {done0, timeout0, cycle_count0}, 6'b110111); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_normal_halt();
      test_timeout();
      test_simultaneous();
      test_abort();
      test_restart();
      test_stagger0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reset_run_controller.md
# reset_run_controller

Synthesizable run controller for single-cycle core bring-up: sequences per-core reset release, times the run, and ends it on a core halt or a cycle-budget timeout. It replaces the fixed reset-then-finish stimulus used around `Single_Cycle_Top` with a parametrised, reusable block. The block supports N staggered reset channels, a programmable hold time and a programmable cycle budget. It sits between the board/bench clock-reset source and one or more core instances.

## Interface
- `RST_HOLD`, 2: cycles core resets stay asserted after `start`; must be ≥1.
- `N_CH`, 1: number of core reset channels.
- `STAGGER`, 0: cycles between successive channel releases; 0 releases all channels together.
- `MAX_CYCLES`, 1024: run cycle budget; must be ≥1.
- `CNT_W`, `$clog2(MAX_CYCLES)+1`: width of `cycle_count`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE and DONE.
- `abort`  in  1  cancel the run; return to IDLE.
- `halt`  in  1  core halt indication (e.g. ecall/ebreak decode), level.
- `core_rst_n`  out  N_CH  per-core active-low reset.
- `running`  out  1  high while in RUN.
- `done`  out  1  sticky; run ended.
- `timeout`  out  1  sticky; run ended by budget exhaustion.
- `cycle_count`  out  CNT_W  cycles elapsed in RUN.

## Operation
- All outputs are registered.
- Reset (`rst`=0, asynchronous) forces state IDLE, `core_rst_n`=0, and `running`/`done`/`timeout`/`cycle_count`=0.
- **IDLE:** cores are held in reset. `start`=1 moves to HOLD, clears the hold counter, and clears `cycle_count`.
- **HOLD:** cores stay in reset for `RST_HOLD` cycles, then the block moves to RELEASE.
- **RELEASE:**
  - Channel i releases (`core_rst_n[i]`=1) `i*STAGGER` cycles after channel 0.
  - Released channels stay released.
  - On the edge that releases channel `N_CH-1`, the block enters RUN and sets `running`=1.
  - With `N_CH`=1 or `STAGGER`=0, RELEASE and RUN entry coincide with the HOLD exit edge.
- **RUN:**
  - `cycle_count` is 0 on the first RUN cycle and increments by 1 per edge.
  - Edge with `halt`=1 → DONE with `done`=1 and `timeout`=0; `cycle_count` freezes at its current value.
  - Edge with `halt`=0 and `cycle_count`==`MAX_CYCLES-1` → DONE with `done`=1 and `timeout`=1; `cycle_count` freezes at `MAX_CYCLES-1`.
  - If `halt` and budget exhaustion occur on the same edge, halt wins and `timeout`=0.
- **DONE:** all `core_rst_n`=0 and `running`=0. `done`, `timeout` and `cycle_count` hold. `start`=1 re-enters HOLD, clearing `done`, `timeout` and `cycle_count`.
- **abort:**
  - In HOLD, RELEASE, RUN or DONE: next edge goes to IDLE with `core_rst_n`=0 and all flags and the count cleared.
  - `abort` has priority over `start`, `halt` and timeout.
  - `abort` is ignored in IDLE.
- `start` is ignored in HOLD, RELEASE and RUN.
- `halt` is ignored outside RUN.
- The counter never wraps, because `CNT_W` covers `MAX_CYCLES`.

## Timing
Reference point: `start` sampled at edge e0.
- State = HOLD after e0.
- `core_rst_n[0]` rises at edge e0+`RST_HOLD`.
- `core_rst_n[i]` rises at edge e0+`RST_HOLD`+`i*STAGGER`.
- `running` rises at e0+`RST_HOLD`+`(N_CH-1)*STAGGER` (= `T_run`).
- Without halt, `done` rises at `T_run`+`MAX_CYCLES`; the run lasts exactly `MAX_CYCLES` cycles.
- Latency from `halt`/`abort` to output change: 1 edge.
- `rst` assertion mid-run is immediate and asynchronous. Release is synchronous to the next edge, with state IDLE.

## Structure
- Package `run_ctrl_pkg` holds:
  - state enum (IDLE, HOLD, RELEASE, RUN, DONE);
  - parameter-legality checks as elaboration-time assertions (`RST_HOLD`≥1, `MAX_CYCLES`≥1, `N_CH`≥1).
- One sub-module, `rst_stagger`: a channel release shift/counter that produces `core_rst_n` from a release-enable, parametrised by `N_CH` and `STAGGER`.
- FSM, hold counter and cycle counter live in the top.

## Test plan
All scenarios use `RST_HOLD`=2, `N_CH`=2, `STAGGER`=1, `MAX_CYCLES`=8, with `start` at edge 0.
- **Reset values:** `rst`=0 → all outputs 0 and `core_rst_n`=2'b00, also when `rst` is asserted asynchronously mid-cycle.
- **Normal halt:**
  - Edge 2: `core_rst_n`=01.
  - Edge 3: `core_rst_n`=11 and `running`=1.
  - `halt`=1 sampled while `cycle_count`=4 → `done`=1, `timeout`=0, count stays 4, `core_rst_n`=00.
- **Timeout:** no halt → `done`=`timeout`=1 at edge 11, `cycle_count`=7.
- **Simultaneous events:** `halt`=1 on the edge where `cycle_count`=7 → `timeout`=0, `done`=1.
- **Abort:** `abort` at edge 2 (RELEASE) → IDLE at the next edge; a later `start` replays identical timing.
- **Restart:** `start` in DONE → flags clear and the release sequence repeats. `start` during RUN has no effect. With `STAGGER`=0, both channels rise at edge 2.
